// File: rtl/np_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// np_mem_pkg
// Shared definitions for the np unified-memory arbiter: default bus widths,
// requester port ids and the host-lock state encoding.
// ---------------------------------------------------------------------------
package np_mem_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int ADDRSIZE_DEF = 12;

    // Requester port ids; the id also sets the fixed-priority order (lowest first)
    localparam int PORT_HOST  = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_INSTR = 2;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/np_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// np_mem_arbiter_if
// Requester-side bus of the memory arbiter. All per-port fields are
// flattened vectors: port p uses bit p of req/we/gnt/rvalid,
// addr[p*ADDRSIZE +: ADDRSIZE] and wdata[p*WIDTH +: WIDTH].
//   master : requesters (drive req/we/addr/wdata, receive gnt/rvalid/rdata)
//   slave  : arbiter    (the reverse)
// rdata is shared by all ports and qualified by the one-hot rvalid.
// ---------------------------------------------------------------------------
interface np_mem_arbiter_if
    import np_mem_pkg::*;
#(
    parameter int NPORTS   = 3,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
);

    logic [NPORTS-1:0]          req;
    logic [NPORTS-1:0]          we;
    logic [NPORTS*ADDRSIZE-1:0] addr;
    logic [NPORTS*WIDTH-1:0]    wdata;
    logic [NPORTS-1:0]          gnt;
    logic [NPORTS-1:0]          rvalid;
    logic [WIDTH-1:0]           rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/np_mem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// np_arb_pick
// Combinational masked priority picker. If any eligible port is urgent, only
// urgent ports compete; otherwise all eligible ports do. The search starts at
// index `start` and wraps, so start=0 gives plain fixed priority.
//   eligible : ports allowed to win this cycle
//   urgent   : starved ports (only meaningful where eligible)
//   start    : first index to examine
//   gnt      : one-hot winner, or all zero when nothing is eligible
// ---------------------------------------------------------------------------
module np_arb_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [N-1:0]  urgent,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt
);

    logic [N-1:0]  cand;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        cand  = (|(urgent & eligible)) ? (urgent & eligible) : eligible;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(start) + i) % N);
            if (!found && cand[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/np_mem_arbiter.sv
// ---------------------------------------------------------------------------
// np_mem_arbiter
// Shares one single-port synchronous SRAM between the np host loader
// (port 0), the CPU data port (port 1) and the CPU instruction fetch (port 2).
// One access per cycle; the command to the SRAM is driven combinationally from
// the winner and read data returns one cycle later on the shared rdata bus.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   bus (slave)        requester bus: req/we/addr/wdata in, gnt/rvalid/rdata out
//   host_lock          host asks for exclusive ownership
//   lock_ack           lock FSM is LOCKED (only port 0 may be granted)
//   mem_en/mem_we      SRAM enable / write enable
//   mem_addr/mem_wdata SRAM address / write data
//   mem_rdata          SRAM read data, valid the cycle after a read command
//
// Build option: NP_ARB_RR_EN selects round-robin base order (pointer = last
// granted port); undefined gives fixed priority 0 > 1 > 2 with no pointer.
// Starved ports (wait counter at MAX_WAIT) beat non-starved ones in both.
// ---------------------------------------------------------------------------
module np_mem_arbiter
    import np_mem_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int NPORTS   = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    np_mem_arbiter_if.slave     bus,
    input  logic                host_lock,
    output logic                lock_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    lock_state_e       lock_q, lock_d;
    logic [CW-1:0]     cnt_q [NPORTS];
    logic [CW-1:0]     cnt_d [NPORTS];
    logic              rd_vld_q, rd_vld_d;
    logic [PW-1:0]     rd_id_q, rd_id_d;

    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] urgent;
    logic [NPORTS-1:0] gnt;
    logic [PW-1:0]     start_idx;
    logic [PW-1:0]     win_id;
    logic              win_any;

    // Eligibility: nothing during reset, only the host while locked.
    always_comb begin
        eligible = bus.req;
        if (reset)
            eligible = '0;
        else if (lock_q == LOCKED)
            eligible = bus.req & (NPORTS'(1) << PORT_HOST);
        urgent = '0;
        for (int p = 0; p < NPORTS; p++)
            urgent[p] = eligible[p] && (cnt_q[p] == WAIT_MAX);
    end

`ifdef NP_ARB_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d     = win_any ? win_id : ptr_q;
        start_idx = (ptr_q == PW'(NPORTS - 1)) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    assign start_idx = '0;
`endif

    np_arb_pick #(
        .N  (NPORTS),
        .IW (PW)
    ) u_pick (
        .eligible (eligible),
        .urgent   (urgent),
        .start    (start_idx),
        .gnt      (gnt)
    );

    // Winner decode and SRAM command; address/data are forced to 0 when idle.
    always_comb begin
        win_id  = '0;
        win_any = |gnt;
        for (int p = 0; p < NPORTS; p++)
            if (gnt[p]) win_id = PW'(p);
        mem_en    = win_any;
        mem_we    = win_any && bus.we[win_id];
        mem_addr  = win_any ? bus.addr[win_id*ADDRSIZE +: ADDRSIZE] : '0;
        mem_wdata = win_any ? bus.wdata[win_id*WIDTH +: WIDTH] : '0;
        bus.gnt   = gnt;
    end

    // Lock FSM next state; a grant already issued on the transition edge
    // completes normally because the read return is tracked separately.
    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            UNLOCKED: if (host_lock)  lock_d = LOCKED;
            LOCKED:   if (!host_lock) lock_d = UNLOCKED;
            default:  lock_d = UNLOCKED;
        endcase
    end

    assign lock_ack = (lock_q == LOCKED);

    // Wait counters: clear on grant or withdrawn request, count only while
    // eligible, hold while locked out.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (!bus.req[p] || gnt[p])
                cnt_d[p] = '0;
            else if (eligible[p] && (cnt_q[p] != WAIT_MAX))
                cnt_d[p] = cnt_q[p] + 1'b1;
        end
    end

    // Read return tracking
    always_comb begin
        rd_vld_d   = win_any && !mem_we;
        rd_id_d    = win_id;
        bus.rvalid = '0;
        for (int p = 0; p < NPORTS; p++)
            bus.rvalid[p] = rd_vld_q && (rd_id_q == PW'(p));
        bus.rdata = rd_vld_q ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q   <= UNLOCKED;
            rd_vld_q <= 1'b0;
            rd_id_q  <= '0;
            for (int p = 0; p < NPORTS; p++)
                cnt_q[p] <= '0;
        end else begin
            lock_q   <= lock_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
            for (int p = 0; p < NPORTS; p++)
                cnt_q[p] <= cnt_d[p];
        end
    end

endmodule

// File: tb/tb_np_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_np_mem_arbiter
// Directed bench for np_mem_arbiter with a behavioural single-port SRAM.
// A table of per-cycle vectors covers basic reads/writes, the host lock,
// same-address hazards and request withdrawal; hand-written sequences cover
// starvation (fixed priority) or round-robin order, and reset during a read.
// ---------------------------------------------------------------------------
module tb_np_mem_arbiter;
    import np_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_lock;
    logic        lock_ack;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    np_mem_arbiter_if #(.NPORTS(3), .WIDTH(32), .ADDRSIZE(12)) bus ();

    np_mem_arbiter #(
        .WIDTH(32), .ADDRSIZE(12), .NPORTS(3), .MAX_WAIT(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .host_lock (host_lock),
        .lock_ack  (lock_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous single-port SRAM
    logic [31:0] sram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [11:0] a0, a1, a2;
        logic [31:0] wd;
        logic        hl;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic [31:0] e_rd;
        logic        e_lock;
        logic [11:0] e_addr;
        logic        e_we;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [2:0] req, logic [2:0] we, logic [11:0] a0, logic [11:0] a1,
                                logic [11:0] a2, logic [31:0] wd, logic hl, logic [2:0] e_gnt,
                                logic [2:0] e_rv, logic [31:0] e_rd, logic e_lock,
                                logic [11:0] e_addr, logic e_we);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd = wd; v.hl = hl;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rd = e_rd; v.e_lock = e_lock;
        v.e_addr = e_addr; v.e_we = e_we;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] we, input logic [11:0] a0,
                         input logic [11:0] a1, input logic [11:0] a2, input logic [31:0] wd,
                         input logic hl);
        bus.req   = req;
        bus.we    = we;
        bus.addr  = {a2, a1, a0};
        bus.wdata = {wd, wd, wd};
        host_lock = hl;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"},       32'(bus.gnt),    32'h0);
        chk({tag, ".rvalid"},    32'(bus.rvalid), 32'h0);
        chk({tag, ".rdata"},     bus.rdata,       32'h0);
        chk({tag, ".lock_ack"},  32'(lock_ack),   32'h0);
        chk({tag, ".mem_en"},    32'(mem_en),     32'h0);
        chk({tag, ".mem_we"},    32'(mem_we),     32'h0);
        chk({tag, ".mem_addr"},  32'(mem_addr),   32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata,       32'h0);
    endtask

    initial begin
        logic [2:0] exp_g;
        logic [2:0] rr_seq [6];

        // Cycle-by-cycle vectors (identical under either base order)
        vt.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 32'h0,        1'b0, 3'b000, 3'b000, 32'h0,        1'b0, 12'h000, 1'b0));
        vt.push_back(mk(3'b001, 3'b001, 12'h005, 12'h000, 12'h000, 32'hDEADBEEF, 1'b0, 3'b001, 3'b000, 32'h0,        1'b0, 12'h005, 1'b1));
        vt.push_back(mk(3'b100, 3'b000, 12'h000, 12'h000, 12'h005, 32'h0,        1'b0, 3'b100, 3'b000, 32'h0,        1'b0, 12'h005, 1'b0));
        vt.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 32'h0,        1'b0, 3'b000, 3'b100, 32'hDEADBEEF, 1'b0, 12'h000, 1'b0));
        vt.push_back(mk(3'b110, 3'b000, 12'h000, 12'h005, 12'h005, 32'h0,        1'b1, 3'b010, 3'b000, 32'h0,        1'b0, 12'h005, 1'b0));
        vt.push_back(mk(3'b111, 3'b001, 12'h010, 12'h005, 12'h005, 32'h42,       1'b1, 3'b001, 3'b010, 32'hDEADBEEF, 1'b1, 12'h010, 1'b1));
        vt.push_back(mk(3'b110, 3'b000, 12'h000, 12'h005, 12'h005, 32'h0,        1'b1, 3'b000, 3'b000, 32'h0,        1'b1, 12'h000, 1'b0));
        vt.push_back(mk(3'b100, 3'b000, 12'h000, 12'h005, 12'h005, 32'h0,        1'b0, 3'b000, 3'b000, 32'h0,        1'b1, 12'h000, 1'b0));
        vt.push_back(mk(3'b110, 3'b000, 12'h000, 12'h010, 12'h005, 32'h0,        1'b0, 3'b010, 3'b000, 32'h0,        1'b0, 12'h010, 1'b0));
        vt.push_back(mk(3'b100, 3'b000, 12'h000, 12'h000, 12'h005, 32'h0,        1'b0, 3'b100, 3'b010, 32'h42,       1'b0, 12'h005, 1'b0));
        vt.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 32'h0,        1'b0, 3'b000, 3'b100, 32'hDEADBEEF, 1'b0, 12'h000, 1'b0));
        vt.push_back(mk(3'b011, 3'b001, 12'h020, 12'h020, 12'h000, 32'h1234,     1'b0, 3'b001, 3'b000, 32'h0,        1'b0, 12'h020, 1'b1));
        vt.push_back(mk(3'b010, 3'b000, 12'h000, 12'h020, 12'h000, 32'h0,        1'b0, 3'b010, 3'b000, 32'h0,        1'b0, 12'h020, 1'b0));
        vt.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 32'h0,        1'b0, 3'b000, 3'b010, 32'h1234,     1'b0, 12'h000, 1'b0));
        vt.push_back(mk(3'b011, 3'b001, 12'h030, 12'h005, 12'h000, 32'h55,       1'b0, 3'b001, 3'b000, 32'h0,        1'b0, 12'h030, 1'b1));
        vt.push_back(mk(3'b010, 3'b000, 12'h000, 12'h010, 12'h000, 32'h0,        1'b0, 3'b010, 3'b000, 32'h0,        1'b0, 12'h010, 1'b0));
        vt.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 32'h0,        1'b0, 3'b000, 3'b010, 32'h42,       1'b0, 12'h000, 1'b0));

        // Reset
        reset = 1'b1;
        drive(3'b000, 3'b000, 12'h0, 12'h0, 12'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_idle("reset");
        reset = 1'b0;

        // Table-driven section
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].req, vt[i].we, vt[i].a0, vt[i].a1, vt[i].a2, vt[i].wd, vt[i].hl);
            #1;
            chk($sformatf("v%0d.gnt", i),       32'(bus.gnt),    32'(vt[i].e_gnt));
            chk($sformatf("v%0d.rvalid", i),    32'(bus.rvalid), 32'(vt[i].e_rv));
            chk($sformatf("v%0d.rdata", i),     bus.rdata,       vt[i].e_rd);
            chk($sformatf("v%0d.lock_ack", i),  32'(lock_ack),   32'(vt[i].e_lock));
            chk($sformatf("v%0d.mem_en", i),    32'(mem_en),     32'(|vt[i].e_gnt));
            chk($sformatf("v%0d.mem_we", i),    32'(mem_we),     32'(vt[i].e_we));
            chk($sformatf("v%0d.mem_addr", i),  32'(mem_addr),   32'(vt[i].e_addr));
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata,       (vt[i].e_gnt != 3'b000) ? vt[i].wd : 32'h0);
        end

`ifndef NP_ARB_RR_EN
        // Starvation: port 2 loses to port 1 for 15 cycles, wins on the 16th,
        // its counter clears, and it wins again after another 15 losses.
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            drive(3'b110, 3'b000, 12'h0, 12'h005, 12'h005, 32'h0, 1'b0);
            #1;
            exp_g = (c == 15 || c == 31) ? 3'b100 : 3'b010;
            chk($sformatf("starve%0d.gnt", c), 32'(bus.gnt), 32'(exp_g));
        end
        @(negedge clk);
        drive(3'b000, 3'b000, 12'h0, 12'h0, 12'h0, 32'h0, 1'b0);
`endif

        // Reset while a read is in flight; also clears the lock
        @(negedge clk);
        drive(3'b100, 3'b000, 12'h0, 12'h0, 12'h005, 32'h0, 1'b1);
        #1;
        chk("rst_a.gnt", 32'(bus.gnt), 32'h4);
        @(negedge clk);
        drive(3'b101, 3'b000, 12'h005, 12'h0, 12'h005, 32'h0, 1'b1);
        #1;
        chk("rst_b.lock_ack", 32'(lock_ack),   32'h1);
        chk("rst_b.rvalid",   32'(bus.rvalid), 32'h4);
        chk("rst_b.rdata",    bus.rdata,       32'hDEADBEEF);
        chk("rst_b.gnt",      32'(bus.gnt),    32'h1);
        reset = 1'b1;
        #1;
        chk("rst_b.gnt_in_reset", 32'(bus.gnt), 32'h0);
        chk("rst_b.mem_en_in_reset", 32'(mem_en), 32'h0);
        @(negedge clk); #1;
        chk("rst_c.rvalid",   32'(bus.rvalid), 32'h0);
        chk("rst_c.lock_ack", 32'(lock_ack),   32'h0);
        reset = 1'b0;
        drive(3'b000, 3'b000, 12'h0, 12'h0, 12'h0, 32'h0, 1'b0);
        @(negedge clk); #1;
        chk_idle("rst_d");

`ifdef NP_ARB_RR_EN
        // Round-robin from a fresh reset: 1,2,0,1,2,0
        rr_seq[0] = 3'b010; rr_seq[1] = 3'b100; rr_seq[2] = 3'b001;
        rr_seq[3] = 3'b010; rr_seq[4] = 3'b100; rr_seq[5] = 3'b001;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(3'b111, 3'b000, 12'h005, 12'h005, 12'h005, 32'h0, 1'b0);
            #1;
            chk($sformatf("rr%0d.gnt", c), 32'(bus.gnt), 32'(rr_seq[c]));
        end
`else
        rr_seq[0] = 3'b000;
        exp_g = rr_seq[0];
`endif

        @(negedge clk);
        drive(3'b000, 3'b000, 12'h0, 12'h0, 12'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/np_mem_arbiter.md
Name: np_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between three requesters of the np core:
  - port 0: host/program loader
  - port 1: CPU data port (address/dataIn/dataOut/wr)
  - port 2: CPU instruction fetch port (in_address/in_dataIn)
- Sits between the np core and a unified memory macro. Lets one memory hold program and data.
- Provides a host lock so the loader can take exclusive ownership while the CPU is held or halted.

Parameters:
- WIDTH, 32, data word width
- ADDRSIZE, 12, word address width
- NPORTS, 3, number of requesters (fixed at 3 for this revision)
- MAX_WAIT, 15, starvation threshold in cycles; counter width is clog2(MAX_WAIT+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  NPORTS  request per port; held with we/addr/wdata stable until gnt
- we  in  NPORTS  1=write, 0=read, per port
- addr  in  NPORTS*ADDRSIZE  flattened addresses, port p at [p*ADDRSIZE +: ADDRSIZE]
- wdata  in  NPORTS*WIDTH  flattened write data
- gnt  out  NPORTS  one-hot accept, same cycle as the memory command
- rvalid  out  NPORTS  one-hot read-data valid, one cycle after a read gnt
- rdata  out  WIDTH  shared read data, qualified by rvalid
- host_lock  in  1  host requests exclusive ownership
- lock_ack  out  1  lock state is LOCKED
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDRSIZE  SRAM address
- mem_wdata  out  WIDTH  SRAM write data
- mem_rdata  in  WIDTH  SRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, lock_ack=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - lock FSM UNLOCKED, all wait counters 0, rr pointer 0
  - An in-flight read is dropped: rvalid stays 0 in the cycle after reset.
- Arbitration and memory command:
  - Arbitration is combinational each cycle. At most one gnt bit is set.
  - mem_en/mem_we/mem_addr/mem_wdata are driven combinationally from the winner in the same cycle. The SRAM samples them at that clock edge.
  - No request: mem_en=0, and addr/wdata are held at 0.
- Read return:
  - The winning port id and the read flag are registered.
  - In the next cycle, rvalid[id]=1 and rdata=mem_rdata.
  - Throughput is one access per cycle, back-to-back.
- Lock FSM (states UNLOCKED, LOCKED):
  - UNLOCKED -> LOCKED on a clk edge with host_lock=1.
  - LOCKED -> UNLOCKED on a clk edge with host_lock=0.
  - lock_ack=1 in LOCKED.
  - In LOCKED, only port 0 is eligible. Ports 1 and 2 wait, and their counters do not increment.
  - A gnt issued in the same cycle as the transition edge still completes, including its rvalid.
- Starvation:
  - Each eligible port with req=1 and gnt=0 increments its counter, saturating at MAX_WAIT.
  - The counter clears on gnt or when req=0.
  - A port with counter==MAX_WAIT is urgent. Urgent ports beat non-urgent ports; ties between urgent ports use the base order.
- Base order without NP_ARB_RR_EN: fixed priority, port 0 > 1 > 2.
- Ordering and hazards:
  - Same-address write and read in one cycle: the winner accesses first, the loser sees the updated memory on its later grant.
  - No forwarding is needed.
- Protocol errors:
  - A requester that drops req before gnt is legal; nothing is issued for it.
  - Changing addr while req=1 and gnt=0 is legal; the value at gnt time is used.

Optional Feature:
- Macro: NP_ARB_RR_EN
- Defined: base order is round-robin.
  - A pointer holds the last granted port.
  - The search starts at pointer+1 mod NPORTS.
  - The pointer updates on every gnt.
  - Urgency still overrides.
- Undefined: fixed priority 0 > 1 > 2, and no pointer register is built.

Decomposition:
- Package np_mem_pkg holds:
  - WIDTH/ADDRSIZE defaults
  - port id constants PORT_HOST=0, PORT_DATA=1, PORT_INSTR=2
  - a lock state enum {UNLOCKED, LOCKED}
- One sub-module: np_arb_pick. It is a combinational masked priority picker taking an eligible vector, an urgent vector and a start index, and returning a one-hot grant. It is instantiated once.

Test Plan:
- Reset, then idle: every output is 0. Read port 2 at addr 0x005 holding 0xDEADBEEF -> gnt[2] in cycle c, rvalid[2]=1 with rdata=0xDEADBEEF in c+1.
- Ports 1 and 2 request reads every cycle, fixed priority -> port 1 granted. Port 2 counter reaches 15 after 15 cycles -> port 2 granted on cycle 16, then its counter clears.
- NP_ARB_RR_EN defined, all three ports requesting continuously -> grant sequence 1,2,0,1,2,0.
- host_lock=1 while ports 1 and 2 request -> lock_ack=1 next cycle, only port 0 grants. Port 0 writes 0x00000042 to 0x010, then host_lock=0 -> port 1 reads 0x010 and gets 0x00000042.
- Same cycle: port 0 writes 0x1234 to 0x020 and port 1 reads 0x020 -> port 0 wins, then port 1 is granted next cycle and returns 0x1234.
- Reset asserted in the cycle after a read gnt -> rvalid stays 0, and all state returns to reset values.
